// File: rtl/nonl_phimap_seq_pkg.sv
// Shared types and elaboration-time helpers for the trigonometric phi expansion.
package nonl_phimap_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of harmonics carried by an odd expansion length.
  function automatic int calc_p(input int q_ord);
    return (q_ord - 1) / 2;
  endfunction

  // Quarter-wave step count for a given ROM index width.
  function automatic int calc_qw(input int lut_width);
    return 1 << (lut_width - 1);
  endfunction

  // One ROM word: round(sin(pi*i/(2*qw)) * 2^(width-2)).
  // The Taylor series converges to double precision over [0, pi/2].
  function automatic int rom_entry(input int i, input int qw, input int width);
    real x;
    real term;
    real sum;
    real scale;
    x = 3.14159265358979323846 * $itor(i) / $itor(2 * qw);
    term = x;
    sum = x;
    for (int n = 1; n <= 12; n++) begin
      term = -term * x * x / $itor((2 * n) * (2 * n + 1));
      sum = sum + term;
    end
    scale = 1.0;
    for (int b = 0; b < width - 2; b++) begin
      scale = scale * 2.0;
    end
    return $rtoi(sum * scale + 0.5);
  endfunction

endpackage

// File: rtl/nonl_phimap_seq_rom.sv
// Quarter-wave sine ROM with two combinational read ports (sin and cos lookups).
module nonl_phimap_seq_rom
  import nonl_phimap_seq_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int LUT_WIDTH = 7
) (
  input  logic [LUT_WIDTH-1:0] sin_idx,
  input  logic [LUT_WIDTH-1:0] cos_idx,
  output logic [WIDTH-1:0]     sin_val,
  output logic [WIDTH-1:0]     cos_val
);

  localparam int QW = calc_qw(LUT_WIDTH);

  logic [WIDTH-1:0] rom_words [QW+1];

  // Table contents are fixed at elaboration from the parameters.
  for (genvar gi = 0; gi <= QW; gi++) begin : g_word
    localparam int ENTRY = rom_entry(gi, QW, WIDTH);
    assign rom_words[gi] = WIDTH'(ENTRY);
  end

  // Indices never exceed QW because the angle map folds the upper quadrants.
  assign sin_val = rom_words[sin_idx];
  assign cos_val = rom_words[cos_idx];

endmodule

// File: rtl/nonl_phimap_seq.sv
// Sequential trig functional-link expansion: one sin/cos harmonic pair per cycle.
module nonl_phimap_seq
  import nonl_phimap_seq_pkg::*;
#(
  parameter int Q_ORD     = 9,
  parameter int WIDTH     = 16,
  parameter int QP        = 12,
  parameter int LUT_WIDTH = 7
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [Q_ORD*WIDTH-1:0]  nonl_x_out_packed,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int P       = calc_p(Q_ORD);
  localparam int QW      = calc_qw(LUT_WIDTH);
  localparam int ANGLE_W = LUT_WIDTH + 1;
  localparam int KW      = $clog2(P + 1);
  localparam int SHIFT   = QP - LUT_WIDTH;
  localparam logic [WIDTH-1:0] RND = WIDTH'(2 ** (SHIFT - 1));

  state_t               state_reg;
  state_t               state_next;
  logic [KW-1:0]        k_reg;
  logic [ANGLE_W-1:0]   acc_reg;
  logic [ANGLE_W-1:0]   xt_reg;
  logic [ANGLE_W-1:0]   xt_in;
  logic signed [WIDTH-1:0] x_round;
  logic                 capture;
  logic                 last;
  logic [LUT_WIDTH-1:0] rom_idx [2];
  logic [WIDTH-1:0]     rom_val [2];
  logic [WIDTH-1:0]     phi_val [2];
  logic [WIDTH-1:0]     slot0_reg;

  // Round x to the angle grid; only the low angle bits matter, so wrap is harmless.
  assign x_round = x_in + RND;
  assign xt_in   = ANGLE_W'(x_round >>> SHIFT);

  assign capture   = in_valid & in_ready;
  assign last      = (k_reg == KW'(P));
  assign out_valid = (state_reg == DONE);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next state and input-side ready; DONE can hand straight over to a new sample.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) state_next = in_valid ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Harmonic counter and phase accumulator: k*xt built by repeated addition.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_reg   <= '0;
      acc_reg <= '0;
      xt_reg  <= '0;
    end else if (capture) begin
      k_reg   <= KW'(1);
      acc_reg <= xt_in;
      xt_reg  <= xt_in;
    end else if (state_reg == RUN) begin
      acc_reg <= acc_reg + xt_reg;
      k_reg   <= last ? '0 : k_reg + KW'(1);
    end
  end

  // Port 0 maps the sine angle, port 1 the same angle advanced by a quarter turn.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic [ANGLE_W-1:0]   angle;
    logic [LUT_WIDTH-1:0] r_ext;
    assign angle        = acc_reg + ANGLE_W'(gi * QW);
    assign r_ext        = {1'b0, angle[LUT_WIDTH-2:0]};
    assign rom_idx[gi]  = angle[LUT_WIDTH-1] ? LUT_WIDTH'(QW) - r_ext : r_ext;
    assign phi_val[gi]  = angle[ANGLE_W-1] ? -rom_val[gi] : rom_val[gi];
  end

  nonl_phimap_seq_rom #(
    .WIDTH     (WIDTH),
    .LUT_WIDTH (LUT_WIDTH)
  ) u_rom (
    .sin_idx (rom_idx[0]),
    .cos_idx (rom_idx[1]),
    .sin_val (rom_val[0]),
    .cos_val (rom_val[1])
  );

  // Slot 0 carries the raw sample, refreshed only when a new sample is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       slot0_reg <= '0;
    else if (capture) slot0_reg <= x_in;
  end

  assign nonl_x_out_packed[WIDTH-1:0] = slot0_reg;

  // Odd slots hold sin_k, even slots cos_k; each is written only on its own RUN cycle.
  for (genvar gi = 1; gi < Q_ORD; gi++) begin : g_slot
    localparam int KS  = (gi + 1) / 2;
    localparam int SEL = 1 - (gi % 2);
    logic [WIDTH-1:0] slot_reg;

    // Capture this harmonic when the counter reaches it.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                     slot_reg <= '0;
      else if (state_reg == RUN && k_reg == KW'(KS)) slot_reg <= phi_val[SEL];
    end

    assign nonl_x_out_packed[gi*WIDTH +: WIDTH] = slot_reg;
  end

endmodule
